// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: op classes, opcodes, field positions, encoder states.
// Build macro INSTR_ENC_ERR_CHECK_EN adds the ERR state used to trap illegal op classes.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_R   = 3'd0,
    OP_J   = 3'd1,
    OP_JAL = 3'd2,
    OP_BEQ = 3'd3,
    OP_LW  = 3'd4,
    OP_SW  = 3'd5
  } op_class_e;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;

  localparam int OPC_LSB    = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1
`ifdef INSTR_ENC_ERR_CHECK_EN
    , ST_ERR = 2'd2
`endif
  } enc_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op < 3'd6;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op class plus register/immediate fields -> 32-bit MIPS word.
// Op classes outside the legal set produce an all-zero word (nop).
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (op)
      OP_R: begin
        word[OPC_LSB +: 6]   = OPC_R;
        word[RS_LSB +: 5]    = rs;
        word[RT_LSB +: 5]    = rt;
        word[RD_LSB +: 5]    = rd;
        word[SHAMT_LSB +: 5] = shamt;
        word[FUNCT_LSB +: 6] = funct;
      end
      OP_J, OP_JAL: begin
        word[OPC_LSB +: 6]     = (op == OP_J) ? OPC_J : OPC_JAL;
        word[TARGET_LSB +: 26] = target;
      end
      OP_BEQ, OP_LW, OP_SW: begin
        word[OPC_LSB +: 6]  = (op == OP_BEQ) ? OPC_BEQ : ((op == OP_LW) ? OPC_LW : OPC_SW);
        word[RS_LSB +: 5]   = rs;
        word[RT_LSB +: 5]   = rt;
        word[IMM_LSB +: 16] = imm;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-entry output register with pass-through drain and a wrapping
// word-address counter. Build macro INSTR_ENC_ERR_CHECK_EN traps illegal op classes in ERR.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
`ifdef INSTR_ENC_ERR_CHECK_EN
  output logic              err,
`endif
  output logic              out_wrap
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef INSTR_ENC_ERR_CHECK_EN
  localparam enc_state_e ST_TRAP = ST_ERR;
`else
  localparam enc_state_e ST_TRAP = ST_FULL;
`endif

  enc_state_e        state_reg, state_next;
  logic [31:0]       data_reg;
  logic [31:0]       packed_word;
  logic [ADDR_W-1:0] addr_reg;
  logic              wrap_reg;
  logic              accept;
  logic              drain;
  logic              illegal;

  instr_pack u_pack (
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .word   (packed_word)
  );

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

`ifdef INSTR_ENC_ERR_CHECK_EN
  assign illegal = ~op_legal(in_op);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // A drain in the same cycle as an illegal accept empties the output before ERR.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_FULL: begin
        if (accept)     state_next = illegal ? ST_TRAP : ST_FULL;
        else if (drain) state_next = ST_IDLE;
      end
      default: state_next = state_reg;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state_reg)
      ST_IDLE: in_ready = 1'b1;
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
`ifdef INSTR_ENC_ERR_CHECK_EN
    err = (state_reg == ST_ERR);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      addr_reg <= BASE;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= drain && (addr_reg == '1);
      if (drain)              addr_reg <= addr_reg + ADDR_W'(1);
      if (accept && !illegal) data_reg <= packed_word;
    end
  end

  assign out_data = data_reg;
  assign out_addr = addr_reg;
  assign out_wrap = wrap_reg;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0: first word address written after reset.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request carries a valid instruction description.
REQ-006 in_ready  output  1  encoder accepts the request this cycle.
REQ-007 in_op  input  3  class: 0 R-type, 1 j, 2 jal, 3 beq, 4 lw, 5 sw; 6 and 7 are illegal.
REQ-008 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-009 in_shamt  input  5 and in_funct  input  6  R-type fields.
REQ-010 in_imm  input  16  immediate or branch offset; in_target  input  26  jump target.
REQ-011 out_valid  output  1  out_data and out_addr hold a word ready to write.
REQ-012 out_ready  input  1  instruction memory accepts the word.
REQ-013 out_addr  output  ADDR_W  word address of out_data.
REQ-014 out_data  output  32  encoded instruction.
REQ-015 out_wrap  output  1  one-cycle pulse when out_addr wraps to 0.

Function
REQ-016 Opcode [31:26] SHALL be 000000 for R-type, 000010 for j, 000011 for jal, 000100 for beq, 100011 for lw, and 101011 for sw.
REQ-017 R-type SHALL pack op|rs|rt|rd|shamt|funct; j/jal SHALL pack op|target; beq/lw/sw SHALL pack op|rs|rt|imm.
REQ-018 A request SHALL transfer when in_valid&in_ready; in_ready = ~out_valid | out_ready (one-entry output register with pass-through drain).
REQ-019 Latency SHALL be 1 cycle: a word accepted in cycle N appears with out_valid=1 in cycle N+1.
REQ-020 out_data/out_addr SHALL remain stable while out_valid&~out_ready.
REQ-021 out_addr SHALL increment by 1 on every out_valid&out_ready; at 2^ADDR_W-1 it SHALL wrap to 0 and pulse out_wrap in the following cycle.
REQ-022 Simultaneous drain and accept SHALL load the new word with the incremented address and keep out_valid=1.
REQ-023 State machine: IDLE (output empty), FULL (word held); ERR exists only per REQ-029.
REQ-024 Transitions: IDLE->FULL on accept; FULL->IDLE on drain without accept; FULL->FULL on drain with accept or on stall.

Reset
REQ-025 On reset the block SHALL set state IDLE, out_valid=0, out_data=0, out_addr=BASE_ADDR, and out_wrap=0.
REQ-026 Reset during FULL SHALL discard the held word without writing it.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is deasserted.

Configuration
REQ-028 Macro INSTR_ENC_ERR_CHECK_EN SHALL select illegal-op handling.
REQ-029 With INSTR_ENC_ERR_CHECK_EN defined: an illegal in_op transfer SHALL enter ERR, hold in_ready=0 and out_valid=0 (after draining any held word), and remain until reset; an output err (1 bit) SHALL be 1 in ERR.
REQ-030 Without INSTR_ENC_ERR_CHECK_EN: an illegal in_op SHALL encode as 32'h00000000 (nop) and be written normally; there SHALL be no err port and no ERR state.

Structure
REQ-031 Shared package mips_pkg SHALL hold the op-class enum, the six 6-bit opcode constants, and the field bit positions.
REQ-032 The combinational packer SHALL be sub-module instr_pack (op class plus fields -> 32-bit word); handshake, address counter, and FSM SHALL be in instr_encoder.

Verification
REQ-033 After reset, send lw rs=2 rt=5 imm=16'h0004 with out_ready=1 -> next cycle out_data=32'h8C450004 and out_addr=BASE_ADDR.
REQ-034 Send back-to-back R-type add (rs=1,rt=2,rd=3,funct=0x20), beq (rs=1,rt=2,imm=0xFFFF), and jal target=0x0000010 -> out_data is 32'h00221820, then 32'h1022FFFF, then 32'h0C000010, with consecutive addresses and no bubbles.
REQ-035 Hold out_ready=0 for 3 cycles with the output full -> in_ready=0, out_data/out_addr stable; release -> word written once, address +1.
REQ-036 ADDR_W=2, BASE_ADDR=3, write 2 words -> addresses 3 then 0, with out_wrap pulsing once.
REQ-037 in_op=6: with INSTR_ENC_ERR_CHECK_EN -> err=1 and in_ready=0 until reset; without it -> out_data=32'h00000000 is written.
REQ-038 Assert reset while FULL with out_ready=0 -> next cycle out_valid=0 and out_addr=BASE_ADDR.
